// File: rtl/router_fsm_np_pkg.sv
// Shared types and helpers for the parametrised router input controller.
package router_fsm_np_pkg;

  // Controller states, binary encoded.
  typedef enum logic [3:0] {
    DECODE_ADDRESS     = 4'd0,
    LOAD_FIRST_DATA    = 4'd1,
    LOAD_DATA          = 4'd2,
    FIFO_FULL_STATE    = 4'd3,
    LOAD_AFTER_FULL    = 4'd4,
    LOAD_PARITY        = 4'd5,
    CHECK_PARITY_ERROR = 4'd6,
    WAIT_TILL_EMPTY    = 4'd7,
    DROP_PACKET        = 4'd8
  } router_state_e;

  localparam int MIN_PORTS = 2;
  localparam int MAX_PORTS = 8;

  // A header address selects a real FIFO only when it is below the port count.
  function automatic logic router_addr_valid(input int unsigned addr,
                                             input int unsigned num_ports);
    return addr < num_ports;
  endfunction

  // Port count must be in range and every port must be reachable by an address.
  function automatic bit router_params_ok(input int num_ports, input int addr_w);
    return (num_ports >= MIN_PORTS) && (num_ports <= MAX_PORTS) &&
           (addr_w >= 1) && (addr_w <= 16) && ((1 << addr_w) >= num_ports);
  endfunction

  // Watchdog counter width; a disabled watchdog still keeps a 1-bit counter.
  function automatic int router_timer_w(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/router_fsm_np_if.sv
// Handshake bundle between the input register block / output FIFOs and the
// router controller. master drives the packet-side inputs, slave is the FSM.
interface router_fsm_np_if #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 2
);
  logic                 pkt_valid;
  logic [ADDR_W-1:0]    din;
  logic                 parity_done;
  logic                 low_pkt_valid;
  logic                 fifo_full;
  logic [NUM_PORTS-1:0] fifo_empty;
  logic [NUM_PORTS-1:0] soft_reset;

  logic                 busy;
  logic                 detect_add;
  logic                 lfd_state;
  logic                 ld_state;
  logic                 full_state;
  logic                 laf_state;
  logic                 write_enb_reg;
  logic                 rst_int_reg;
  logic                 drop_state;
  logic [NUM_PORTS-1:0] dest_sel;
  logic                 wait_timeout;

  modport master (
    output pkt_valid, din, parity_done, low_pkt_valid, fifo_full,
           fifo_empty, soft_reset,
    input  busy, detect_add, lfd_state, ld_state, full_state, laf_state,
           write_enb_reg, rst_int_reg, drop_state, dest_sel, wait_timeout
  );

  modport slave (
    input  pkt_valid, din, parity_done, low_pkt_valid, fifo_full,
           fifo_empty, soft_reset,
    output busy, detect_add, lfd_state, ld_state, full_state, laf_state,
           write_enb_reg, rst_int_reg, drop_state, dest_sel, wait_timeout
  );
endinterface

// File: rtl/router_fsm_np_wait_timer.sv
// Bounded wait watchdog: counts cycles while enabled, reports expiry on the
// last permitted cycle. WAIT_TIMEOUT=0 disables expiry entirely.
module router_fsm_np_wait_timer
  import router_fsm_np_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int CNT_W = router_timer_w(WAIT_TIMEOUT);
  localparam logic [CNT_W-1:0] LAST =
    (WAIT_TIMEOUT == 0) ? '0 : CNT_W'(WAIT_TIMEOUT - 1);

  logic [CNT_W-1:0] wait_cnt;

  // Count while waiting; any exit from the wait state starts the next wait at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (en && !clr && (WAIT_TIMEOUT != 0)) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  assign expired = (WAIT_TIMEOUT != 0) && en && (wait_cnt == LAST);

endmodule

// File: rtl/router_fsm_np.sv
// Router input-side controller for NUM_PORTS destination FIFOs. Moore FSM
// with invalid-address dropping and a bounded wait for a busy destination.
module router_fsm_np
  import router_fsm_np_pkg::*;
#(
  parameter int NUM_PORTS    = 3,
  parameter int ADDR_W       = 2,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst,
  router_fsm_np_if.slave bus
);

  if (!router_params_ok(NUM_PORTS, ADDR_W)) begin : g_bad_params
    $error("router_fsm_np: illegal NUM_PORTS/ADDR_W combination");
  end

  router_state_e        state;
  router_state_e        next_state;
  logic [ADDR_W-1:0]    addr_q;
  logic [NUM_PORTS-1:0] dest_sel_q;

  logic din_valid;
  logic empty_din;
  logic empty_sel;
  logic soft_sel;
  logic soft_hit;
  logic expired;
  logic timeout_taken;

  assign din_valid = router_addr_valid(32'(bus.din), NUM_PORTS);

  // Pick the empty/soft-reset flags of the incoming and the latched address.
  // Out-of-range addresses read as zero instead of indexing past the vector.
  always_comb begin
    empty_din = 1'b0;
    empty_sel = 1'b0;
    soft_sel  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (bus.din == ADDR_W'(i)) begin
        empty_din = bus.fifo_empty[i];
      end
      if (addr_q == ADDR_W'(i)) begin
        empty_sel = bus.fifo_empty[i];
        soft_sel  = bus.soft_reset[i];
      end
    end
  end

  // Soft reset only matters while a packet owns the selected port.
  assign soft_hit = soft_sel &&
                    (state != DECODE_ADDRESS) && (state != DROP_PACKET);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= DECODE_ADDRESS;
    end else begin
      state <= next_state;
    end
  end

  // Next-state selection; soft reset overrides every other transition.
  always_comb begin
    next_state    = state;
    timeout_taken = 1'b0;
    if (soft_hit) begin
      next_state = DECODE_ADDRESS;
    end else begin
      case (state)
        DECODE_ADDRESS: begin
          if (bus.pkt_valid) begin
            if (!din_valid)     next_state = DROP_PACKET;
            else if (empty_din) next_state = LOAD_FIRST_DATA;
            else                next_state = WAIT_TILL_EMPTY;
          end
        end
        LOAD_FIRST_DATA: next_state = LOAD_DATA;
        LOAD_DATA: begin
          if (bus.fifo_full)       next_state = FIFO_FULL_STATE;
          else if (!bus.pkt_valid) next_state = LOAD_PARITY;
        end
        FIFO_FULL_STATE: begin
          if (!bus.fifo_full) next_state = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (bus.parity_done)        next_state = DECODE_ADDRESS;
          else if (bus.low_pkt_valid) next_state = LOAD_PARITY;
          else                        next_state = LOAD_DATA;
        end
        LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: begin
          next_state = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        end
        WAIT_TILL_EMPTY: begin
          // A FIFO draining on the expiry cycle still lets the packet through.
          if (empty_sel) begin
            next_state = LOAD_FIRST_DATA;
          end else if (expired) begin
            next_state    = DROP_PACKET;
            timeout_taken = 1'b1;
          end
        end
        DROP_PACKET: begin
          if (!bus.pkt_valid) next_state = DECODE_ADDRESS;
        end
        default: next_state = DECODE_ADDRESS;
      endcase
    end
  end

  // Latch the header address and its one-hot write select; clear the select
  // whenever the packet is abandoned so nothing is written for it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q     <= '0;
      dest_sel_q <= '0;
    end else if (soft_hit) begin
      dest_sel_q <= '0;
    end else if ((state == DECODE_ADDRESS) && bus.pkt_valid) begin
      addr_q     <= bus.din;
      dest_sel_q <= din_valid ? (NUM_PORTS'(1) << bus.din) : '0;
    end else if (next_state == DROP_PACKET) begin
      dest_sel_q <= '0;
    end
  end

  router_fsm_np_wait_timer #(
    .WAIT_TIMEOUT (WAIT_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .en      (state == WAIT_TILL_EMPTY),
    .clr     (next_state != WAIT_TILL_EMPTY),
    .expired (expired)
  );

  assign bus.detect_add    = (state == DECODE_ADDRESS);
  assign bus.lfd_state     = (state == LOAD_FIRST_DATA);
  assign bus.ld_state      = (state == LOAD_DATA);
  assign bus.full_state    = (state == FIFO_FULL_STATE);
  assign bus.laf_state     = (state == LOAD_AFTER_FULL);
  assign bus.rst_int_reg   = (state == CHECK_PARITY_ERROR);
  assign bus.drop_state    = (state == DROP_PACKET);
  assign bus.busy          = (state == LOAD_FIRST_DATA)    ||
                             (state == FIFO_FULL_STATE)    ||
                             (state == LOAD_AFTER_FULL)    ||
                             (state == LOAD_PARITY)        ||
                             (state == CHECK_PARITY_ERROR) ||
                             (state == WAIT_TILL_EMPTY);
  assign bus.write_enb_reg = (state == LOAD_FIRST_DATA) ||
                             (state == LOAD_DATA)       ||
                             (state == LOAD_AFTER_FULL) ||
                             (state == LOAD_PARITY);
  assign bus.dest_sel      = dest_sel_q;
  assign bus.wait_timeout  = timeout_taken;

endmodule

// File: tb/tb_router_fsm_np.sv
// Directed bench for router_fsm_np: a 3-port instance (watchdog 8) and a
// 5-port instance with 3-bit addresses, driven step by step.
module tb_router_fsm_np;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // Flag vector order: detect_add, lfd, ld, full, laf, rst_int, drop.
  localparam logic [6:0] F_DEC  = 7'b1000000;
  localparam logic [6:0] F_LFD  = 7'b0100000;
  localparam logic [6:0] F_LD   = 7'b0010000;
  localparam logic [6:0] F_FULL = 7'b0001000;
  localparam logic [6:0] F_LAF  = 7'b0000100;
  localparam logic [6:0] F_CPE  = 7'b0000010;
  localparam logic [6:0] F_DROP = 7'b0000001;
  localparam logic [6:0] F_NONE = 7'b0000000;

  router_fsm_np_if #(.NUM_PORTS(3), .ADDR_W(2)) if3 ();
  router_fsm_np_if #(.NUM_PORTS(5), .ADDR_W(3)) if5 ();

  router_fsm_np #(.NUM_PORTS(3), .ADDR_W(2), .WAIT_TIMEOUT(8)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (if3)
  );

  router_fsm_np #(.NUM_PORTS(5), .ADDR_W(3), .WAIT_TIMEOUT(8)) dut5 (
    .clk (clk),
    .rst (rst),
    .bus (if5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  function automatic logic [17:0] ex(logic [6:0] f, logic b, logic w,
                                     logic [7:0] d, logic t);
    return {f, b, w, d, t};
  endfunction

  function automatic logic [17:0] obs3();
    return {if3.detect_add, if3.lfd_state, if3.ld_state, if3.full_state,
            if3.laf_state, if3.rst_int_reg, if3.drop_state,
            if3.busy, if3.write_enb_reg, 5'b0, if3.dest_sel, if3.wait_timeout};
  endfunction

  function automatic logic [17:0] obs5();
    return {if5.detect_add, if5.lfd_state, if5.ld_state, if5.full_state,
            if5.laf_state, if5.rst_int_reg, if5.drop_state,
            if5.busy, if5.write_enb_reg, 3'b0, if5.dest_sel, if5.wait_timeout};
  endfunction

  task automatic chk(input string tag, input logic [17:0] o, input logic [17:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    if3.pkt_valid = 1'b0; if3.din = '0; if3.parity_done = 1'b0;
    if3.low_pkt_valid = 1'b0; if3.fifo_full = 1'b0;
    if3.fifo_empty = '0; if3.soft_reset = '0;
    if5.pkt_valid = 1'b0; if5.din = '0; if5.parity_done = 1'b0;
    if5.low_pkt_valid = 1'b0; if5.fifo_full = 1'b0;
    if5.fifo_empty = '0; if5.soft_reset = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset3", obs3(), ex(F_DEC, 0, 0, 8'h00, 0));
    chk("reset5", obs5(), ex(F_DEC, 0, 0, 8'h00, 0));
    rst = 1'b1;

    // T1: normal packet to port 1
    if3.fifo_empty = 3'b111; if3.din = 2'd1; if3.pkt_valid = 1'b1;
    tick(); chk("t1_lfd", obs3(), ex(F_LFD,  1, 1, 8'h02, 0));
    tick(); chk("t1_ld0", obs3(), ex(F_LD,   0, 1, 8'h02, 0));
    tick(); chk("t1_ld1", obs3(), ex(F_LD,   0, 1, 8'h02, 0));
    if3.pkt_valid = 1'b0;
    tick(); chk("t1_lp",  obs3(), ex(F_NONE, 1, 1, 8'h02, 0));
    tick(); chk("t1_cpe", obs3(), ex(F_CPE,  1, 0, 8'h02, 0));
    tick(); chk("t1_dec", obs3(), ex(F_DEC,  0, 0, 8'h02, 0));

    // T2: FIFO full mid-payload, low_pkt_valid path, full after parity check
    if3.pkt_valid = 1'b1;
    tick(); chk("t2_lfd", obs3(), ex(F_LFD, 1, 1, 8'h02, 0));
    tick(); chk("t2_ld",  obs3(), ex(F_LD,  0, 1, 8'h02, 0));
    if3.fifo_full = 1'b1;
    tick(); chk("t2_full", obs3(), ex(F_FULL, 1, 0, 8'h02, 0));
    if3.fifo_full = 1'b0;
    tick(); chk("t2_laf", obs3(), ex(F_LAF, 1, 1, 8'h02, 0));
    if3.low_pkt_valid = 1'b1; if3.pkt_valid = 1'b0;
    tick(); chk("t2_lp", obs3(), ex(F_NONE, 1, 1, 8'h02, 0));
    if3.low_pkt_valid = 1'b0;
    tick(); chk("t2_cpe", obs3(), ex(F_CPE, 1, 0, 8'h02, 0));
    if3.fifo_full = 1'b1;
    tick(); chk("t2_full2", obs3(), ex(F_FULL, 1, 0, 8'h02, 0));
    if3.fifo_full = 1'b0;
    tick(); chk("t2_laf2", obs3(), ex(F_LAF, 1, 1, 8'h02, 0));
    if3.parity_done = 1'b1;
    tick(); chk("t2_dec", obs3(), ex(F_DEC, 0, 0, 8'h02, 0));
    if3.parity_done = 1'b0;

    // T3: invalid address 3 is dropped (header + 4 bytes, then parity)
    if3.din = 2'd3; if3.pkt_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); chk("t3_drop", obs3(), ex(F_DROP, 0, 0, 8'h00, 0));
    end
    if3.pkt_valid = 1'b0;
    tick(); chk("t3_dec", obs3(), ex(F_DEC, 0, 0, 8'h00, 0));

    // T4a: port 2 never drains, watchdog expires on the 8th wait cycle
    if3.fifo_empty = 3'b011; if3.din = 2'd2; if3.pkt_valid = 1'b1;
    tick();
    if3.pkt_valid = 1'b0;
    for (int i = 1; i < 8; i++) begin
      chk("t4_wait", obs3(), ex(F_NONE, 1, 0, 8'h04, 0));
      tick();
    end
    chk("t4_pulse", obs3(), ex(F_NONE, 1, 0, 8'h04, 1));
    tick(); chk("t4_drop", obs3(), ex(F_DROP, 0, 0, 8'h00, 0));
    tick(); chk("t4_dec",  obs3(), ex(F_DEC,  0, 0, 8'h00, 0));

    // T4b: port 2 drains on the expiry cycle, so the packet proceeds
    if3.pkt_valid = 1'b1;
    tick();
    if3.pkt_valid = 1'b0;
    for (int i = 1; i < 8; i++) begin
      chk("t4b_wait", obs3(), ex(F_NONE, 1, 0, 8'h04, 0));
      tick();
    end
    if3.fifo_empty = 3'b111;
    #1;
    chk("t4b_nopulse", obs3(), ex(F_NONE, 1, 0, 8'h04, 0));
    tick(); chk("t4b_lfd", obs3(), ex(F_LFD, 1, 1, 8'h04, 0));
    tick(); tick(); tick();
    tick(); chk("t4b_dec", obs3(), ex(F_DEC, 0, 0, 8'h04, 0));

    // T5: soft reset of another port ignored, of the selected port honoured
    if3.din = 2'd1; if3.pkt_valid = 1'b1;
    tick(); tick(); chk("t5_ld", obs3(), ex(F_LD, 0, 1, 8'h02, 0));
    if3.soft_reset = 3'b001;
    tick(); chk("t5_other", obs3(), ex(F_LD, 0, 1, 8'h02, 0));
    if3.soft_reset = 3'b010;
    tick(); chk("t5_soft", obs3(), ex(F_DEC, 0, 0, 8'h00, 0));
    if3.soft_reset = 3'b000; if3.pkt_valid = 1'b0;
    tick(); chk("t5_idle", obs3(), ex(F_DEC, 0, 0, 8'h00, 0));

    // Async reset in the middle of a packet
    if3.din = 2'd0; if3.pkt_valid = 1'b1;
    tick(); tick(); chk("ar_ld", obs3(), ex(F_LD, 0, 1, 8'h01, 0));
    #2;
    rst = 1'b0; if3.pkt_valid = 1'b0;
    #1;
    chk("ar_abort", obs3(), ex(F_DEC, 0, 0, 8'h00, 0));
    rst = 1'b1;

    // T6: 5-port instance, port 4 completes, addresses 5..7 dropped
    if5.fifo_empty = 5'b11111; if5.din = 3'd4; if5.pkt_valid = 1'b1;
    tick(); chk("t6_lfd", obs5(), ex(F_LFD, 1, 1, 8'h10, 0));
    tick(); chk("t6_ld",  obs5(), ex(F_LD,  0, 1, 8'h10, 0));
    if5.pkt_valid = 1'b0;
    tick(); chk("t6_lp",  obs5(), ex(F_NONE, 1, 1, 8'h10, 0));
    tick(); chk("t6_cpe", obs5(), ex(F_CPE,  1, 0, 8'h10, 0));
    tick(); chk("t6_dec", obs5(), ex(F_DEC,  0, 0, 8'h10, 0));
    for (int a = 5; a < 8; a++) begin
      if5.din = 3'(a); if5.pkt_valid = 1'b1;
      tick(); chk("t6_drop", obs5(), ex(F_DROP, 0, 0, 8'h00, 0));
      if5.pkt_valid = 1'b0;
      tick(); chk("t6_back", obs5(), ex(F_DEC, 0, 0, 8'h00, 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
